// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared state encodings and helpers for the CPU debug sequencer
package cpu_dbg_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_HALT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_STEP  = 2'd2;
    localparam logic [STATE_W-1:0] ST_BREAK = 2'd3;

    // Divider counter width; a divide-by-one still needs a one-bit counter.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchroniser with delay flop for level and rising-edge outputs
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic lvl,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/halt/single-step/breakpoint clock-enable sequencer for the core
import cpu_dbg_pkg::*;

module cpu_step_ctrl #(
    parameter int DIV       = 100,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                run_sw,
    input  logic                step_pulse,
    input  logic                halt_req,
    input  logic                bp_en,
    input  logic [31:0]         bp_addr,
    input  logic [31:0]         pc,
    output logic                cpu_ce,
    output logic                halted,
    output logic                bp_hit,
    output logic [STATE_W-1:0]  state,
    output logic [31:0]         inst_count
);

    localparam int                     CW       = cnt_width(DIV);
    localparam logic [CW-1:0]          CNT_MAX  = CW'(DIV - 1);
    localparam logic [STATE_W-1:0]     ST_RESET = RESET_RUN ? ST_RUN : ST_HALT;

    logic [STATE_W-1:0] st_q;
    logic [STATE_W-1:0] st_d;
    logic [CW-1:0]      cnt_q;
    logic               skip_q;
    logic [31:0]        inst_cnt;

    logic run_lvl;
    logic run_rise;
    logic step_lvl_unused;
    logic step_edge;
    logic tick;
    logic brk;
    logic ce_raw;
    logic leave_brk;

    sync_edge u_run_sync (
        .clk   (sysclk),
        .reset (reset),
        .d     (run_sw),
        .lvl   (run_lvl),
        .rise  (run_rise)
    );

    sync_edge u_step_sync (
        .clk   (sysclk),
        .reset (reset),
        .d     (step_pulse),
        .lvl   (step_lvl_unused),
        .rise  (step_edge)
    );

    assign tick   = (st_q == ST_RUN) && (cnt_q == CNT_MAX);
    assign brk    = bp_en && (pc == bp_addr) && !skip_q;
    assign ce_raw = (st_q == ST_STEP) || (tick && !brk && !halt_req && run_lvl);
    // The core must never advance while reset is held, whatever state is left over.
    assign cpu_ce = ce_raw && !reset;

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_RUN: begin
                if (halt_req || !run_lvl) st_d = ST_HALT;
                else if (tick && brk)     st_d = ST_BREAK;
            end
            ST_HALT: begin
                if (halt_req)       st_d = ST_HALT;
                else if (step_edge) st_d = ST_STEP;
                else if (run_lvl)   st_d = ST_RUN;
            end
            ST_STEP: st_d = ST_HALT;
            ST_BREAK: begin
                if (halt_req)       st_d = ST_HALT;
                else if (step_edge) st_d = ST_STEP;
                else if (run_rise)  st_d = ST_RUN;
            end
            default: st_d = ST_HALT;
        endcase
    end

    assign leave_brk = (st_q == ST_BREAK) && ((st_d == ST_STEP) || (st_d == ST_RUN));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            st_q     <= ST_RESET;
            cnt_q    <= '0;
            skip_q   <= 1'b0;
            inst_cnt <= '0;
        end else begin
            st_q <= st_d;

            if ((st_d == ST_RUN) && (st_q != ST_RUN)) begin
                cnt_q <= '0;
            end else if (st_q == ST_RUN) begin
                cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            end

            // skip lets the breakpoint instruction execute once before re-arming.
            if (leave_brk)   skip_q <= 1'b1;
            else if (cpu_ce) skip_q <= 1'b0;

            if (cpu_ce) inst_cnt <= inst_cnt + 32'd1;
        end
    end

    assign state      = st_q;
    assign inst_count = inst_cnt;
    assign halted     = reset ? !RESET_RUN : ((st_q == ST_HALT) || (st_q == ST_BREAK));
    assign bp_hit     = !reset && (st_q == ST_BREAK);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
`timescale 1ns/1ps
import cpu_dbg_pkg::*;

module tb_cpu_step_ctrl;

    logic        sysclk;
    logic        reset;
    logic        run_sw;
    logic        step_pulse;
    logic        halt_req;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  state;
    logic [31:0] inst_count;

    logic        run_sw2;
    logic        ce2;
    logic        halted2;
    logic        bp_hit2;
    logic [1:0]  state2;
    logic [31:0] count2;

    logic        pc_load;
    logic [31:0] pc_load_val;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_step_ctrl #(.DIV(4), .RESET_RUN(1'b1)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .run_sw     (run_sw),
        .step_pulse (step_pulse),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .state      (state),
        .inst_count (inst_count)
    );

    cpu_step_ctrl #(.DIV(1), .RESET_RUN(1'b0)) dut_div1 (
        .sysclk     (sysclk),
        .reset      (reset),
        .run_sw     (run_sw2),
        .step_pulse (1'b0),
        .halt_req   (1'b0),
        .bp_en      (1'b0),
        .bp_addr    (32'h0),
        .pc         (32'h0),
        .cpu_ce     (ce2),
        .halted     (halted2),
        .bp_hit     (bp_hit2),
        .state      (state2),
        .inst_count (count2)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Minimal core: eight instructions looping from 0x00400000 to 0x0040001C.
    always @(posedge sysclk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (cpu_ce) pc <= (pc == 32'h0040001C) ? 32'h00400000 : pc + 32'd4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
        int n = 0;
        while (state != s && n < limit) begin
            cyc();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic count_ce(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (cpu_ce) cnt++;
        end
    endtask

    initial begin
        int nce;
        int first;
        int n;
        int base2;

        reset = 1'b1; run_sw = 1'b1; step_pulse = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h00400010; run_sw2 = 1'b1;
        pc_load = 1'b1; pc_load_val = 32'h00400000;

        // Reset values
        cyc(); cyc(); cyc();
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_halted_rr0", 32'(halted2), 32'd1);
        reset = 1'b0; pc_load = 1'b0;
        check("post_rst_state", 32'(state), 32'(ST_RUN));
        check("post_rst_count", inst_count, 32'd0);

        // 1: free run, DIV=4
        nce = 0; first = 0;
        for (int k = 1; k <= 43; k++) begin
            cyc();
            if (k == 1) check("sync_not_ready_halt", 32'(state), 32'(ST_HALT));
            if (cpu_ce) begin
                if (first == 0) first = k;
                nce++;
            end
        end
        check("run_first_ce", 32'(first), 32'd6);
        check("run_ce_count", 32'(nce), 32'd10);
        check("run_inst_count", inst_count, 32'd10);

        // 2: stop, then single step
        run_sw = 1'b0;
        cyc(); cyc();
        check("stop_still_run", 32'(state), 32'(ST_RUN));
        cyc();
        check("stop_halt", 32'(state), 32'(ST_HALT));
        count_ce(20, n);
        check("halt_no_ce", 32'(n), 32'd0);
        step_pulse = 1'b1;
        cyc(); cyc();
        check("step_lat_ce0", 32'(cpu_ce), 32'd0);
        cyc();
        check("step_state", 32'(state), 32'(ST_STEP));
        check("step_ce", 32'(cpu_ce), 32'd1);
        cyc();
        check("step_back_halt", 32'(state), 32'(ST_HALT));
        check("step_count", inst_count, 32'd11);
        count_ce(20, n);
        check("held_button_one_step", 32'(n), 32'd0);
        step_pulse = 1'b0;
        cyc(); cyc(); cyc();

        // 3: breakpoint, hold, resume on run_sw rise, re-arm
        pc_load = 1'b1; pc_load_val = 32'h00400000;
        cyc();
        pc_load = 1'b0; bp_en = 1'b1; run_sw = 1'b1;
        wait_state(ST_BREAK, 100, "bp_reach");
        check("bp_pc", pc, 32'h00400010);
        check("bp_ce", 32'(cpu_ce), 32'd0);
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_count", inst_count, 32'd15);
        count_ce(100, n);
        check("bp_hold_no_ce", 32'(n), 32'd0);
        check("bp_hold_state", 32'(state), 32'(ST_BREAK));
        run_sw = 1'b0;
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("bp_sw_low_state", 32'(state), 32'(ST_BREAK));
        run_sw = 1'b1;
        n = 0;
        while (!cpu_ce && n < 50) begin
            cyc();
            n++;
        end
        check("resume_ce", 32'(cpu_ce), 32'd1);
        check("resume_pc", pc, 32'h00400010);
        check("resume_state", 32'(state), 32'(ST_RUN));
        wait_state(ST_BREAK, 100, "bp_rearm");
        check("bp_rearm_pc", pc, 32'h00400010);
        check("bp_rearm_count", inst_count, 32'd23);

        // 4: step out of BREAK lands in HALT
        run_sw = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        step_pulse = 1'b1;
        cyc(); cyc();
        check("bstep_wait_state", 32'(state), 32'(ST_BREAK));
        cyc();
        check("bstep_ce", 32'(cpu_ce), 32'd1);
        check("bstep_pc", pc, 32'h00400010);
        cyc();
        check("bstep_halt", 32'(state), 32'(ST_HALT));
        check("bstep_bp_hit", 32'(bp_hit), 32'd0);
        check("bstep_count", inst_count, 32'd24);
        step_pulse = 1'b0;
        cyc(); cyc(); cyc();

        // 5: halt_req beats tick+brk; halt_req during STEP keeps ce
        pc_load = 1'b1; pc_load_val = 32'h00400010;
        cyc();
        pc_load = 1'b0; run_sw = 1'b1;
        wait_state(ST_RUN, 10, "hr_enter_run");
        cyc(); cyc(); cyc();
        check("hr_tick_brk_ce", 32'(cpu_ce), 32'd0);
        halt_req = 1'b1;
        #1;
        check("hr_ce", 32'(cpu_ce), 32'd0);
        cyc();
        check("hr_state", 32'(state), 32'(ST_HALT));
        check("hr_bp_hit", 32'(bp_hit), 32'd0);
        check("hr_count", inst_count, 32'd24);
        run_sw = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        halt_req = 1'b0;
        cyc();
        step_pulse = 1'b1;
        cyc(); cyc(); cyc();
        halt_req = 1'b1;
        #1;
        check("hr_step_ce", 32'(cpu_ce), 32'd1);
        cyc();
        check("hr_step_halt", 32'(state), 32'(ST_HALT));
        check("hr_step_count", inst_count, 32'd25);
        halt_req = 1'b0; step_pulse = 1'b0;
        cyc(); cyc(); cyc();

        // 6: reset in STEP, reset in BREAK, counter wrap
        step_pulse = 1'b1;
        cyc(); cyc(); cyc();
        check("rs_step_state", 32'(state), 32'(ST_STEP));
        reset = 1'b1; step_pulse = 1'b0;
        #1;
        check("rs_step_ce", 32'(cpu_ce), 32'd0);
        check("rs_step_halted", 32'(halted), 32'd0);
        cyc();
        check("rs_step_state_after", 32'(state), 32'(ST_RUN));
        check("rs_step_count", inst_count, 32'd0);
        reset = 1'b0;
        pc_load = 1'b1; pc_load_val = 32'h0040000C;
        cyc();
        pc_load = 1'b0; run_sw = 1'b1;
        wait_state(ST_BREAK, 100, "rs_brk_reach");
        check("rs_brk_pc", pc, 32'h00400010);
        reset = 1'b1;
        #1;
        check("rs_brk_bp_hit", 32'(bp_hit), 32'd0);
        check("rs_brk_halted", 32'(halted), 32'd0);
        cyc();
        check("rs_brk_state", 32'(state), 32'(ST_RUN));
        check("rs_brk_count", inst_count, 32'd0);
        reset = 1'b0; run_sw = 1'b0;
        wait_state(ST_HALT, 10, "wrap_halt");
        @(negedge sysclk);
        dut.inst_cnt = 32'hFFFF_FFFF;
        cyc();
        step_pulse = 1'b1;
        cyc(); cyc(); cyc();
        check("wrap_step_ce", 32'(cpu_ce), 32'd1);
        cyc();
        check("wrap_count", inst_count, 32'd0);
        step_pulse = 1'b0;

        // DIV=1 instance: ce every cycle while running
        base2 = count2;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (ce2) n++;
        end
        check("div1_ce_count", 32'(n), 32'd10);
        check("div1_inst_delta", count2 - 32'(base2), 32'd10);
        check("div1_state", 32'(state2), 32'(ST_RUN));
        check("div1_bp_hit", 32'(bp_hit2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
